// File: rtl/axis_spi_pkg.sv
// axis_spi_pkg: shared types for the AXI-Stream SPI master/slave pair.
// Word width, mode register layout and slave FSM states.
package axis_spi_pkg;

  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_reg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2
  } slv_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: flop chain bringing one SPI pin into the clk domain.
// Reset value is chosen per pin so an idle bus looks idle.
module spi_slave_sync
  import axis_spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // shift the pin level through the chain
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/axis_spi_slave.sv
// axis_spi_slave: oversampled SPI responder with AXI-Stream ports.
// RX bytes go out on m_axis, reply bytes come in on s_axis.
module axis_spi_slave
  import axis_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = axis_spi_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  spi_sclk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  tx_underrun_o,
  output logic                  rx_overrun_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  slv_state_e            state, state_nx;
  spi_mode_reg_t         mode;
  logic                  sclk_s, cs_n_s, mosi_s, sclk_q;
  logic                  lead, trail, smp, shf, last_bit;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_tx, tx_buf, rx_byte;
  logic [DATA_WIDTH-2:0] shift_rx;
  logic                  tx_buf_valid, tx_empty;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk_i), .arstn(arstn_i), .d(spi_sclk_i), .q(sclk_s)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk_i), .arstn(arstn_i), .d(spi_cs_n_i), .q(cs_n_s)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_i), .arstn(arstn_i), .d(spi_mosi_i), .q(mosi_s)
  );

  assign lead  = (sclk_q == mode.cpol) && (sclk_s != mode.cpol);
  assign trail = (sclk_q != mode.cpol) && (sclk_s == mode.cpol);
  assign smp   = (state == XFER) && !cs_n_s && (mode.cpha ? trail : lead);
  assign shf   = (state == XFER) && !cs_n_s && (mode.cpha ? lead : trail);

  assign last_bit = bit_cnt == CW'(DATA_WIDTH - 1);
  assign rx_byte  = {shift_rx, mosi_s};

  assign busy_o        = !cs_n_s;
  assign spi_miso_oe_o = !cs_n_s;
  assign s_axis_tready = !tx_buf_valid;

  // previous sclk sample and mode latched while deselected
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      sclk_q <= 1'b0;
      mode   <= '0;
    end else begin
      sclk_q <= sclk_s;
      if (state == IDLE && cs_n_s) mode <= '{cpol: cpol_i, cpha: cpha_i};
    end
  end

  // state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) state <= IDLE;
    else          state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (!cs_n_s) state_nx = LOAD;
      LOAD: state_nx = cs_n_s ? IDLE : XFER;
      XFER: begin
        if (cs_n_s)               state_nx = IDLE;
        else if (smp && last_bit) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // one-entry reply buffer, drained at every byte start
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      tx_buf       <= '0;
      tx_buf_valid <= 1'b0;
    end else if (s_axis_tvalid && !tx_buf_valid) begin
      tx_buf       <= s_axis_tdata;
      tx_buf_valid <= 1'b1;
    end else if (state == LOAD) begin
      tx_buf_valid <= 1'b0;
    end
  end

  // bit engine: load reply, sample mosi, drive miso
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      shift_tx   <= '0;
      shift_rx   <= '0;
      bit_cnt    <= '0;
      tx_empty   <= 1'b0;
      spi_miso_o <= 1'b0;
    end else if (cs_n_s) begin
      bit_cnt    <= '0;
      tx_empty   <= 1'b0;
      spi_miso_o <= 1'b0;
    end else if (state == LOAD) begin
      shift_tx <= tx_buf_valid ? tx_buf : '0;
      tx_empty <= !tx_buf_valid;
      bit_cnt  <= '0;
      if (!mode.cpha) spi_miso_o <= tx_buf_valid && tx_buf[DATA_WIDTH-1];
    end else begin
      if (smp) begin
        shift_rx <= rx_byte[DATA_WIDTH-2:0];
        bit_cnt  <= bit_cnt + CW'(1);
        tx_empty <= 1'b0;
      end
      if (shf) begin
        if (bit_cnt != '0) begin
          shift_tx   <= shift_tx << 1;
          spi_miso_o <= shift_tx[DATA_WIDTH-2];
        end else if (mode.cpha) begin
          spi_miso_o <= shift_tx[DATA_WIDTH-1];
        end
      end
    end
  end

  // deliver rx bytes; underrun is flagged when the byte really begins
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      tx_underrun_o <= 1'b0;
      rx_overrun_o  <= 1'b0;
    end else begin
      tx_underrun_o <= smp && (bit_cnt == '0) && tx_empty;
      rx_overrun_o  <= 1'b0;
      if (smp && last_bit) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tdata  <= rx_byte;
          m_axis_tvalid <= 1'b1;
        end else begin
          rx_overrun_o <= 1'b1;
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_spi_slave.sv
// tb_axis_spi_slave: host-side SPI model driving axis_spi_slave.
// Replies, deliveries and pulses are predicted from queues.
module tb_axis_spi_slave;
  import axis_spi_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int H  = 8;

  logic          clk_i = 1'b0;
  logic          arstn_i = 1'b0;
  logic          cpol_i = 1'b0, cpha_i = 1'b0;
  logic          spi_sclk_i = 1'b0, spi_cs_n_i = 1'b1, spi_mosi_i = 1'b0;
  logic          spi_miso_o, spi_miso_oe_o;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          busy_o, tx_underrun_o, rx_overrun_o;

  int n_cmp = 0, n_err = 0;
  int und_cnt = 0, ovr_cnt = 0, und_exp = 0, ovr_exp = 0;
  logic          hs = 1'b0;
  logic [DW-1:0] feed_q[$], model_q[$];
  logic [DW-1:0] host_tx[$], host_rx[$];
  logic [DW-1:0] rx_got[$], rx_exp[$];

  axis_spi_slave dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i),
    .spi_sclk_i(spi_sclk_i), .spi_cs_n_i(spi_cs_n_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy_o(busy_o), .tx_underrun_o(tx_underrun_o),
    .rx_overrun_o(rx_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  initial forever begin
    @(posedge clk_i);
    hs <= arstn_i && s_axis_tvalid && s_axis_tready;
  end

  initial begin
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    forever begin
      @(negedge clk_i);
      if (hs && feed_q.size() != 0) void'(feed_q.pop_front());
      s_axis_tvalid = feed_q.size() != 0;
      s_axis_tdata  = (feed_q.size() != 0) ? feed_q[0] : '0;
    end
  end

  initial begin
    logic          stall;
    logic [DW-1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_cmp++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) begin
            n_err++;
            $display("FAIL axis_hold: tvalid=%b tdata=%h want 1/%h",
                     m_axis_tvalid, m_axis_tdata, held);
          end
        end
        if (m_axis_tvalid && m_axis_tready) rx_got.push_back(m_axis_tdata);
        if (tx_underrun_o) und_cnt++;
        if (rx_overrun_o) ovr_cnt++;
        stall = m_axis_tvalid && !m_axis_tready;
        held  = m_axis_tdata;
      end
    end
  end

  task automatic host_run(input logic pol, input logic pha, input int abort);
    host_rx = {};
    cpol_i = pol;
    cpha_i = pha;
    spi_sclk_i = pol;
    clk_wait(H);
    spi_cs_n_i = 1'b0;
    clk_wait(H);
    foreach (host_tx[b]) begin
      logic [DW-1:0] r;
      r = '0;
      for (int i = DW - 1; i >= 0; i--) begin
        if (abort != 0 && DW - 1 - i == abort) break;
        if (!pha) begin
          spi_mosi_i = host_tx[b][i];
          clk_wait(H);
          r[i] = spi_miso_o;
          spi_sclk_i = ~pol;
          clk_wait(H);
          spi_sclk_i = pol;
        end else begin
          spi_sclk_i = ~pol;
          spi_mosi_i = host_tx[b][i];
          clk_wait(H);
          r[i] = spi_miso_o;
          spi_sclk_i = pol;
          clk_wait(H);
        end
      end
      host_rx.push_back(r);
    end
    clk_wait(H);
    spi_cs_n_i = 1'b1;
    clk_wait(2 * H);
  endtask

  task automatic xfer_case(input string name, input logic pol,
                           input logic pha, input logic rdy,
                           input int abort);
    logic [DW-1:0] exp_reply[$];
    logic          slot_full;
    logic [DW-1:0] slot;
    exp_reply = {};
    slot_full = 1'b0;
    slot = '0;
    rx_got = {};
    rx_exp = {};
    und_cnt = 0;
    ovr_cnt = 0;
    und_exp = 0;
    ovr_exp = 0;
    m_axis_tready = rdy;
    host_run(pol, pha, abort);
    foreach (host_tx[b]) begin
      if (model_q.size() != 0) begin
        exp_reply.push_back(model_q.pop_front());
      end else begin
        exp_reply.push_back('0);
        und_exp++;
      end
      if (abort == 0) begin
        if (rdy) rx_exp.push_back(host_tx[b]);
        else if (!slot_full) begin
          slot_full = 1'b1;
          slot = host_tx[b];
        end else ovr_exp++;
      end
    end
    if (abort == 0 && model_q.size() != 0) void'(model_q.pop_front());
    m_axis_tready = 1'b1;
    clk_wait(4);
    if (slot_full) rx_exp.push_back(slot);
    n_cmp++;
    if (rx_got.size() != rx_exp.size()) begin
      n_err++;
      $display("FAIL %s rx_count: got %0d want %0d",
               name, rx_got.size(), rx_exp.size());
    end
    foreach (rx_exp[i]) begin
      if (i < rx_got.size()) begin
        n_cmp++;
        if (rx_got[i] !== rx_exp[i]) begin
          n_err++;
          $display("FAIL %s rx[%0d]: got %h want %h",
                   name, i, rx_got[i], rx_exp[i]);
        end
      end
    end
    if (abort == 0) begin
      foreach (exp_reply[i]) begin
        n_cmp++;
        if (host_rx[i] !== exp_reply[i]) begin
          n_err++;
          $display("FAIL %s miso[%0d]: got %h want %h",
                   name, i, host_rx[i], exp_reply[i]);
        end
      end
    end
    n_cmp++;
    if (und_cnt != und_exp) begin
      n_err++;
      $display("FAIL %s underrun: got %0d want %0d", name, und_cnt, und_exp);
    end
    n_cmp++;
    if (ovr_cnt != ovr_exp) begin
      n_err++;
      $display("FAIL %s overrun: got %0d want %0d", name, ovr_cnt, ovr_exp);
    end
  endtask

  task automatic reply(input logic [DW-1:0] v);
    feed_q.push_back(v);
    model_q.push_back(v);
  endtask

  task automatic test_reset();
    logic [14:0] got;
    #1;
    got = {spi_miso_o, spi_miso_oe_o, s_axis_tready, m_axis_tvalid,
           busy_o, tx_underrun_o, rx_overrun_o, m_axis_tdata};
    n_cmp++;
    if (got !== 15'b0010000_00000000) begin
      n_err++;
      $display("FAIL reset_values: got %b want %b", got, 15'b0010000_00000000);
    end
    clk_wait(2);
    arstn_i = 1'b1;
    clk_wait(4);
  endtask

  task automatic test_mode0();
    host_tx = {8'hA5};
    reply(8'h3C);
    clk_wait(4);
    xfer_case("mode0", 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_modes();
    host_tx = {8'h81};
    reply(8'h12);
    xfer_case("mode1", 1'b0, 1'b1, 1'b1, 0);
    host_tx = {8'h7E};
    reply(8'h34);
    xfer_case("mode2", 1'b1, 1'b0, 1'b1, 0);
    host_tx = {8'hC3};
    reply(8'h56);
    xfer_case("mode3", 1'b1, 1'b1, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    host_tx = {8'h01, 8'h02, 8'h03};
    reply(8'hAA);
    reply(8'hBB);
    reply(8'hCC);
    xfer_case("back_to_back", 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_abort();
    host_tx = {8'hC9};
    reply(8'h77);
    xfer_case("abort", 1'b0, 1'b0, 1'b1, 5);
    n_cmp++;
    if (busy_o !== 1'b0 || spi_miso_oe_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: busy=%b oe=%b want 0/0", busy_o, spi_miso_oe_o);
    end
    host_tx = {8'h55};
    reply(8'h21);
    xfer_case("after_abort", 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_underrun();
    host_tx = {8'h9D, 8'h4B};
    xfer_case("underrun", 1'b0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      int nb;
      int nr;
      nb = $urandom_range(1, 3);
      nr = $urandom_range(0, nb);
      host_tx = {};
      for (int i = 0; i < nb; i++) host_tx.push_back(DW'($urandom));
      for (int i = 0; i < nr; i++) reply(DW'($urandom));
      xfer_case("random", 1'($urandom), 1'($urandom), 1'b1, 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] got;
    feed_q.push_back(8'hFF);
    cpol_i = 1'b0;
    cpha_i = 1'b0;
    spi_sclk_i = 1'b0;
    clk_wait(H);
    spi_cs_n_i = 1'b0;
    clk_wait(H);
    for (int i = 0; i < 3; i++) begin
      spi_mosi_i = 1'b1;
      clk_wait(H);
      spi_sclk_i = 1'b1;
      clk_wait(H);
      spi_sclk_i = 1'b0;
    end
    clk_wait(4);
    arstn_i = 1'b0;
    #1;
    got = {spi_miso_o, spi_miso_oe_o, s_axis_tready, m_axis_tvalid,
           busy_o, tx_underrun_o, rx_overrun_o, m_axis_tdata};
    n_cmp++;
    if (got !== 15'b0010000_00000000) begin
      n_err++;
      $display("FAIL reset_mid: got %b want %b", got, 15'b0010000_00000000);
    end
    feed_q = {};
    model_q = {};
    spi_cs_n_i = 1'b1;
    spi_mosi_i = 1'b0;
    clk_wait(4);
    arstn_i = 1'b1;
    clk_wait(4);
    host_tx = {8'hF0};
    reply(DW'($urandom));
    xfer_case("reset_recover", 1'b0, 1'b0, 1'b1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_spi_slave.md
# axis_spi_slave

SPI responder (slave) with AXI-Stream data ports, the counterpart of the team's AXI-Stream SPI master. It oversamples the external SCLK/CS_N/MOSI in the system clock domain and shifts received bytes out on a master AXI-Stream port. Reply bytes are taken from a slave AXI-Stream port and driven on MISO. It sits behind the pads of any FPGA design that must answer an external SPI host.

## Interface
- DATA_WIDTH, 8: bits per SPI word and AXIS tdata width (from axis_spi_pkg).
- SYNC_STAGES, 2: synchronizer depth on sclk/cs_n/mosi (≥2).
- clk_i  in  1  system clock; must be ≥ 8× SCLK frequency.
- arstn_i  in  1  asynchronous active-low reset.
- cpol_i  in  1  clock idle level; sampled only while cs_n synced high.
- cpha_i  in  1  0: sample on leading edge, 1: sample on trailing edge; sampled as cpol_i.
- spi_sclk_i  in  1  SPI clock from the host.
- spi_cs_n_i  in  1  chip select, active low.
- spi_mosi_i  in  1  host data.
- spi_miso_o  out  1  reply data, MSB first.
- spi_miso_oe_o  out  1  MISO output enable; high only while CS is asserted (synced).
- s_axis_tdata  in  DATA_WIDTH  next reply byte.
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- m_axis_tdata  out  DATA_WIDTH  received byte.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- busy_o  out  1  high while CS is asserted (synced).
- tx_underrun_o  out  1  one-cycle pulse: byte started with the TX buffer empty.
- rx_overrun_o  out  1  one-cycle pulse: received byte dropped.

## Operation
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, busy_o=0, both pulses 0, synchronizers cleared with sclk=0 and cs_n=1.
- Leading edge: synced SCLK leaves the cpol level. Trailing edge: SCLK returns to the cpol level. Edges are detected against the previous synced sample.
- Sample edge = leading if cpha=0, else trailing. Shift edge is the opposite edge.
- TX buffer holds one entry. s_axis_tready = !tx_buf_valid. The buffer is consumed (load into the shift register) at each byte start.
- FSM IDLE → LOAD → XFER:
  - IDLE: cs_n synced high; mode latched. On cs_n synced low → LOAD.
  - LOAD (1 cycle): shift_tx ← buffer, or 0x00 with tx_underrun_o pulse if the buffer is empty. bit_cnt ← 0. cpha=0: drive MSB now. → XFER.
  - XFER:
    - Sample edge: shift MOSI into shift_rx and increment bit_cnt.
    - Shift edge: drive the next TX bit. For cpha=1, the first shift edge drives the MSB.
    - When bit_cnt reaches DATA_WIDTH on a sample edge: push the RX byte and go → LOAD. Back-to-back bytes need no CS toggle.
- RX push: if m_axis_tvalid=0 or m_axis_tready=1 that cycle, load m_axis_tdata and set tvalid. Otherwise drop the byte, pulse rx_overrun_o, and leave the held byte unchanged.
- CS deassert mid-byte (any state): go to IDLE next cycle, discard the partial RX byte with no push. A TX byte already loaded is lost; the buffer is not refilled from it. spi_miso_oe_o drops with busy_o.
- SCLK edges while in IDLE or LOAD are ignored.
- bit_cnt width is $clog2(DATA_WIDTH+1) and never wraps within a byte.

## Timing
- Input-to-edge-detect latency is SYNC_STAGES+1 clk cycles.
- MISO update happens 1 clk after the detected shift edge, i.e. SYNC_STAGES+2 clk after the SCLK pin edge. The host must sample ≥ half an SCLK period after its shift edge, hence the ≥8× ratio.
- cpha=0: the first MISO bit is valid SYNC_STAGES+3 clk after CS falls. The host must wait ≥ that time before the first edge.
- m_axis_tvalid rises 1 clk after the final sample edge is detected.
- A TX byte accepted by 1 clk before LOAD is used for that byte.
- AXIS rules: tvalid is never withdrawn without a handshake, and tdata is stable while tvalid && !tready.

## Structure
- Add to axis_spi_pkg: the slave FSM state enum (IDLE, LOAD, XFER). Reuse DATA_WIDTH and the cpol/cpha field definitions from spi_mode_reg_t.
- Sub-module spi_slave_sync: SYNC_STAGES flop chain with reset value parameter, instantiated for sclk (0), cs_n (1) and mosi (0).

## Test plan
- Mode 0, host sends 0xA5, TX buffer preloaded 0x3C → m_axis_tdata=0xA5 one push; host reads 0x3C; no pulses.
- Modes 1, 2 and 3, host sends 0x81/0x7E/0xC3 with replies 0x12/0x34/0x56 → bytes match both directions in each mode.
- Three back-to-back bytes 0x01,0x02,0x03 under one CS, m_axis_tready held low after the first → only 0x01 delivered, rx_overrun_o pulses twice.
- CS raised after 5 bits → no m_axis push, busy_o and spi_miso_oe_o low, next full transfer 0x55 received correctly.
- No TX data supplied → host reads 0x00 and tx_underrun_o pulses once per byte.
- arstn_i asserted mid-byte → all outputs return to reset values immediately; after release, transfer 0xF0 succeeds.
